packet_receiver: RTL and testbench
==================================

// Module: packet_receiver
// PURPOSE
//  Gigabit Ethernet receive framer, the inbound counterpart of the packet streamer. Runs on the PHY RX clock.
//  Takes demuxed RGMII bytes, strips preamble/SFD, checks length, RX_ER and CRC-32, and strips the FCS.
//  Emits payload (DA..last pre-FCS byte) as a byte stream with SOP/EOP and per-frame status.
//  The stream feeds a CPU-side FIFO; the counters go to CPU in_ports.
// PARAMETERS
//  MIN_LEN  64    min frame bytes after SFD incl. FCS; shorter = error
//  MAX_LEN  1518  max frame bytes after SFD incl. FCS; longer = error
// PORTS
//  clk                  in   1   phy_rx_clk, 125 MHz, rising edge only
//  reset_n              in   1   asynchronous reset, active-low
//  phy_rx_demux_data    in   8   RX byte, bit 0 = first bit on wire
//  phy_rx_demux_ctl     in   2   [0]=RX_DV, [1]=RX_DV^RX_ER (RGMII encoding)
//  my_mac               in   48  station address, [47:40]=first DA byte on wire
//  dout                 out  8   payload byte
//  dout_valid           out  1   dout qualifier, one cycle per byte, no backpressure
//  dout_sop             out  1   with valid: first byte of frame
//  dout_eop             out  1   with valid: last byte of frame; frame_ok/frame_err valid here
//  frame_ok, frame_err  out  1   status at EOP; exactly one high when dout_eop=1, both 0 otherwise
//  frame_count          out  16  frames ending with frame_ok; wraps at 16 bits
//  err_count            out  16  frames ending in error, including runts with no output; wraps
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, CRC=FFFFFFFF, state=WAIT.
//  - Input stage: dv=ctl[0], er=ctl[0]^ctl[1], data registered 1 cycle (r_dv, r_er, r_data).
//  - WAIT: r_dv=0 -> IDLE. Reset leaves the FSM in WAIT, so a frame in progress at reset release is ignored.
//  - IDLE: r_dv=1 and r_data=55 -> PRE. Any other byte with r_dv=1 -> WAIT.
//  - PRE: 55 -> stay. D5 -> DATA (len=0, CRC=FFFFFFFF, err=0). Other byte -> WAIT.
//    r_dv=0 -> IDLE. None of these transitions touch the counters.
//  - DATA, each r_dv=1 cycle: CRC update (reflected, poly EDB88320), err|=r_er.
//    len++ saturating at 2047. Byte enters a 5-deep delay line.
//    When the line is full, its oldest byte goes to dout with dout_valid=1 the next cycle.
//    The first byte emitted carries dout_sop.
//  - DATA, r_dv=0 (end of frame): CRC residue must equal DEBB20E3.
//    len>=5: the next cycle emits the oldest byte (byte len-5) with dout_eop=1 (sop too if len=5).
//    The remaining 4 FCS bytes are discarded.
//    frame_ok = crc_good & ~err & MIN_LEN<=len<=MAX_LEN; frame_err=~frame_ok; increment matching counter.
//    len<5: no output; err_count++ in the same cycle.
//    Then -> IDLE. No gap cycle is required before the next preamble.
//  - Latency: payload byte k appears on dout 6 clk after it is presented on phy_rx_demux_data.
//  - Output registers hold their last value when dout_valid=0. Only the flags are cleared.
//  - Simultaneous counter increment and wrap: FFFF -> 0000, no saturation.
//  - RX_ER asserted while r_dv=0 (carrier extend/false carrier) is ignored.
// CONFIGURATION
//  `define RX_DA_FILTER_EN:
//    Compare the first 6 payload bytes to my_mac; FF:FF:FF:FF:FF:FF also matches.
//    Mismatch forces frame_ok=0 / frame_err=1 at EOP. The frame counts in err_count.
//    Bytes are still emitted; the downstream FIFO discards frames with frame_err.
//    If len<6 the compare is incomplete and counts as a mismatch.
//  Undefined: my_mac ignored and no compare logic is built; status depends on CRC/length/ER only.
// TESTING
//  - Good frame: 7x55,D5, 60 bytes 00..3B, correct FCS -> 60 dout bytes 00..3B.
//    sop on 00, eop+frame_ok on 3B, frame_count=1, err_count=0.
//  - Same frame with bit 0 of payload byte 10 flipped -> 60 bytes out, eop with frame_err; err_count=1.
//  - RX_ER (ctl=01) on one byte mid-payload, good CRC -> frame_err at eop; err_count=1.
//  - Runt 55,D5,AA,BB,CC -> no dout_valid, err_count=1.
//    55,54,D5,... -> no output, no count change.
//  - reset_n low mid-payload, released with dv=1 -> no output for that frame.
//    Next good frame after a dv=0 gap -> frame_count=1.
//  - RX_DA_FILTER_EN, my_mac=02:00:00:00:00:01: DA=02..01 -> ok; DA=FF*6 -> ok; DA=02..02 -> frame_err.
//  - Back-to-back good 1518-byte frames with 12-cycle IFG -> both ok; 1519-byte frame -> frame_err.

Source files
------------

// File: rtl/packet_receiver.sv
// Gigabit Ethernet RX framer: preamble/SFD strip, CRC-32/length/RX_ER check, FCS strip.
// Optional destination-address filter when RX_DA_FILTER_EN is defined.
module packet_receiver #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  phy_rx_demux_data,
  input  logic [1:0]  phy_rx_demux_ctl,
  input  logic [47:0] my_mac,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_IDLE,
    S_PRE,
    S_DATA
  } state_t;

  localparam logic [31:0] POLY    = 32'hEDB8_8320;
  localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] LEN_SAT = 11'd2047;

  state_t state, state_next;

  logic        r_dv;
  logic        r_er;
  logic [7:0]  r_data;
  logic [31:0] crc;
  logic [10:0] len;
  logic        err;
  logic [4:0][7:0] line;

  logic start;
  logic data_en;
  logic eof;
  logic da_ok;
  logic frame_good;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    return x;
  endfunction

  // r_dv resets high so WAIT only exits on a real idle byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dv   <= 1'b1;
      r_er   <= 1'b0;
      r_data <= 8'h00;
    end else begin
      r_dv   <= phy_rx_demux_ctl[0];
      r_er   <= phy_rx_demux_ctl[0] ^ phy_rx_demux_ctl[1];
      r_data <= phy_rx_demux_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_WAIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_WAIT: if (!r_dv) state_next = S_IDLE;
      S_IDLE:
        if (r_dv)
          state_next = (r_data == 8'h55) ? S_PRE : S_WAIT;
      S_PRE:
        if (!r_dv)                 state_next = S_IDLE;
        else if (r_data == 8'hD5)  state_next = S_DATA;
        else if (r_data != 8'h55)  state_next = S_WAIT;
      S_DATA: if (!r_dv) state_next = S_IDLE;
      default: state_next = S_WAIT;
    endcase
  end

  assign start   = (state == S_PRE) && r_dv && (r_data == 8'hD5);
  assign data_en = (state == S_DATA) && r_dv;
  assign eof     = (state == S_DATA) && !r_dv;

`ifdef RX_DA_FILTER_EN
  logic       da_uc;
  logic       da_bc;
  logic [7:0] mac_byte;

  always_comb begin
    mac_byte = 8'h00;
    unique case (len[2:0])
      3'd0:    mac_byte = my_mac[47:40];
      3'd1:    mac_byte = my_mac[39:32];
      3'd2:    mac_byte = my_mac[31:24];
      3'd3:    mac_byte = my_mac[23:16];
      3'd4:    mac_byte = my_mac[15:8];
      3'd5:    mac_byte = my_mac[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      da_uc <= 1'b0;
      da_bc <= 1'b0;
    end else if (start) begin
      da_uc <= 1'b1;
      da_bc <= 1'b1;
    end else if (data_en && len < 11'd6) begin
      if (r_data != mac_byte) da_uc <= 1'b0;
      if (r_data != 8'hFF)    da_bc <= 1'b0;
    end
  end

  assign da_ok = (len >= 11'd6) && (da_uc || da_bc);
`else
  logic unused_mac;
  assign unused_mac = ^my_mac;
  assign da_ok      = 1'b1;
`endif

  assign frame_good = (crc == RESIDUE) && !err && da_ok
                   && (len >= 11'(MIN_LEN))
                   && (len <= 11'(MAX_LEN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc         <= 32'hFFFF_FFFF;
      len         <= 11'd0;
      err         <= 1'b0;
      line        <= '0;
      dout        <= 8'h00;
      dout_valid  <= 1'b0;
      dout_sop    <= 1'b0;
      dout_eop    <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= 16'h0000;
      err_count   <= 16'h0000;
    end else begin
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      if (start) begin
        crc <= 32'hFFFF_FFFF;
        len <= 11'd0;
        err <= 1'b0;
      end
      if (data_en) begin
        crc  <= crc_step(crc, r_data);
        err  <= err | r_er;
        line <= {line[3:0], r_data};
        if (len != LEN_SAT) len <= len + 11'd1;
        if (len >= 11'd5) begin
          dout       <= line[4];
          dout_valid <= 1'b1;
          dout_sop   <= (len == 11'd5);
        end
      end
      // Oldest byte is the last payload byte; the four younger ones are FCS.
      if (eof) begin
        if (len >= 11'd5) begin
          dout       <= line[4];
          dout_valid <= 1'b1;
          dout_sop   <= (len == 11'd5);
          dout_eop   <= 1'b1;
          frame_ok   <= frame_good;
          frame_err  <= !frame_good;
          if (frame_good) frame_count <= frame_count + 16'd1;
          else            err_count   <= err_count + 16'd1;
        end else begin
          err_count <= err_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_receiver.sv
// Scoreboard bench for packet_receiver: directed frames in, monitor checks the byte stream.
// Define RX_DA_FILTER_EN to exercise the address filter build.
module tb_packet_receiver;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       ok;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic [1:0]  rx_ctl;
  logic [47:0] my_mac = 48'h02_00_00_00_00_01;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_sop;
  logic        dout_eop;
  logic        frame_ok;
  logic        frame_err;
  logic [15:0] frame_count;
  logic [15:0] err_count;

  exp_t        exp_q[$];
  logic [7:0]  pl[$];
  logic [15:0] exp_fc = 16'd0;
  logic [15:0] exp_ec = 16'd0;
  int          tests = 0;
  int          fails = 0;
  int          idle_bad = 0;

  packet_receiver dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .phy_rx_demux_data (rx_data),
    .phy_rx_demux_ctl  (rx_ctl),
    .my_mac            (my_mac),
    .dout              (dout),
    .dout_valid        (dout_valid),
    .dout_sop          (dout_sop),
    .dout_eop          (dout_eop),
    .frame_ok          (frame_ok),
    .frame_err         (frame_err),
    .frame_count       (frame_count),
    .err_count         (err_count)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      if (dout_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_byte got=%02h sop=%b eop=%b",
                   dout, dout_sop, dout_eop);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({dout, dout_sop, dout_eop, frame_ok, frame_err} !== e) begin
            fails++;
            $display("FAIL stream got d=%02h s=%b e=%b ok=%b er=%b want d=%02h s=%b e=%b ok=%b er=%b",
                     dout, dout_sop, dout_eop, frame_ok, frame_err,
                     e.d, e.sop, e.eop, e.ok, e.err);
          end
        end
      end else if (dout_sop || dout_eop || frame_ok || frame_err) begin
        idle_bad++;
      end
    end
  end

  task automatic chk(input string nm, input logic [47:0] a, input logic [47:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, a, x);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  function automatic bit da_pass();
    logic [47:0] da;
    if (pl.size() < 6) return 1'b0;
    da = {pl[0], pl[1], pl[2], pl[3], pl[4], pl[5]};
    return (da == my_mac) || (da == 48'hFFFF_FFFF_FFFF);
  endfunction

  task automatic drive(input logic [7:0] b, input logic [1:0] c);
    @(negedge clk);
    rx_data = b;
    rx_ctl  = c;
  endtask

  task automatic make_pl(input int n, input logic [47:0] da, input bit use_da);
    pl = {};
    for (int k = 0; k < n; k++)
      pl.push_back((use_da && k < 6) ? da[47-8*k -: 8] : k[7:0]);
  endtask

  task automatic send_frame(input bit ok_in, input int flip_idx,
                            input int er_idx, input int ifg);
    logic [31:0] c;
    exp_t        e;
    bit          ok;
    int          n;
    n  = pl.size();
    ok = ok_in;
`ifdef RX_DA_FILTER_EN
    ok = ok & da_pass();
`endif
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) c = crc_byte(c, pl[k]);
    c = ~c;
    for (int k = 0; k < n; k++) begin
      e.d   = pl[k] ^ ((k == flip_idx) ? 8'h01 : 8'h00);
      e.sop = (k == 0);
      e.eop = (k == n - 1);
      e.ok  = e.eop & ok;
      e.err = e.eop & ~ok;
      exp_q.push_back(e);
    end
    if (ok) exp_fc++;
    else    exp_ec++;
    repeat (7) drive(8'h55, 2'b11);
    drive(8'hD5, 2'b11);
    for (int k = 0; k < n; k++)
      drive(pl[k] ^ ((k == flip_idx) ? 8'h01 : 8'h00),
            (k == er_idx) ? 2'b01 : 2'b11);
    for (int i = 0; i < 4; i++) drive(c[8*i +: 8], 2'b11);
    repeat (ifg) drive(8'h00, 2'b00);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_count"}, {32'h0, frame_count}, {32'h0, exp_fc});
    chk({tag, "_err_count"}, {32'h0, err_count}, {32'h0, exp_ec});
  endtask

  initial begin
    int w;
    reset_n = 1'b0;
    rx_data = 8'h00;
    rx_ctl  = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {43'h0, dout_valid, dout_sop, dout_eop, frame_ok, frame_err}, 48'h0);
    chk("rst_dout", {40'h0, dout}, 48'h0);
    check_counts("rst");
    reset_n = 1'b1;
    repeat (3) drive(8'h00, 2'b00);

    make_pl(60, 48'h0, 1'b0);
    send_frame(1'b1, -1, -1, 12);
    check_counts("good");

    send_frame(1'b0, 10, -1, 12);
    check_counts("crc_bad");

    send_frame(1'b0, -1, 20, 12);
    check_counts("rx_er");

    repeat (8) drive(8'hAB, 2'b10);
    drive(8'h00, 2'b00);
    make_pl(60, my_mac, 1'b1);
    send_frame(1'b1, -1, -1, 12);
    check_counts("false_carrier");

    drive(8'h55, 2'b11); drive(8'hD5, 2'b11);
    drive(8'hAA, 2'b11); drive(8'hBB, 2'b11); drive(8'hCC, 2'b11);
    repeat (6) drive(8'h00, 2'b00);
    exp_ec++;
    check_counts("runt");

    drive(8'h55, 2'b11); drive(8'h54, 2'b11); drive(8'hD5, 2'b11);
    for (int k = 0; k < 20; k++) drive(8'h60 + k[7:0], 2'b11);
    repeat (6) drive(8'h00, 2'b00);
    check_counts("bad_pre");

    make_pl(59, my_mac, 1'b1);
    send_frame(1'b0, -1, -1, 12);
    check_counts("len63");

    make_pl(60, my_mac, 1'b1);
    send_frame(1'b1, -1, -1, 12);
    make_pl(60, 48'hFFFF_FFFF_FFFF, 1'b1);
    send_frame(1'b1, -1, -1, 12);
    make_pl(60, 48'h02_00_00_00_00_02, 1'b1);
    send_frame(1'b1, -1, -1, 12);
    check_counts("da_filter");

    make_pl(1514, my_mac, 1'b1);
    send_frame(1'b1, -1, -1, 12);
    send_frame(1'b1, -1, -1, 12);
    make_pl(1515, my_mac, 1'b1);
    send_frame(1'b0, -1, -1, 12);
    check_counts("max_len");

    repeat (7) drive(8'h55, 2'b11);
    drive(8'hD5, 2'b11);
    for (int k = 0; k < 3; k++) drive(8'h40 + k[7:0], 2'b11);
    @(negedge clk);
    reset_n = 1'b0;
    rx_data = 8'h43;
    exp_fc  = 16'd0;
    exp_ec  = 16'd0;
    repeat (2) drive(8'h44, 2'b11);
    chk("midrst_valid", {47'h0, dout_valid}, 48'h0);
    check_counts("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    rx_data = 8'h46;
    for (int k = 0; k < 10; k++) drive(8'h60 + k[7:0], 2'b11);
    repeat (12) drive(8'h00, 2'b00);
    check_counts("after_rst");
    make_pl(60, my_mac, 1'b1);
    send_frame(1'b1, -1, -1, 12);
    check_counts("post_rst_good");

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("queue_drained", 48'(exp_q.size()), 48'h0);
    chk("idle_flags", 48'(idle_bad), 48'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
